// File: rtl/id_ex_stage.sv
// Decode stage with bypassed register file, load-use stall, two-word immediate
// assembly and the ID/EX pipeline register feeding execute.
module id_ex_stage #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned N_REGS = 8,
    parameter int unsigned CTRL_W = 24,
    localparam int unsigned AW    = $clog2(N_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [15:0]       instruction,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              ctrl_reg_write,
    input  logic              ctrl_mem_read,
    input  logic              ctrl_needs_imm,
    input  logic              flush,
    input  logic              wb_we,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall_out,
    output logic              out_valid,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic [AW-1:0]     out_dst,
    output logic [DATA_W-1:0] out_rdata1,
    output logic [DATA_W-1:0] out_rdata2,
    output logic [DATA_W-1:0] out_imm,
    output logic [3:0]        out_shamt
);

    typedef enum logic {S_DECODE, S_IMM} state_t;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic              reg_write;
        logic              mem_read;
        logic [AW-1:0]     dst;
        logic [DATA_W-1:0] rdata1;
        logic [DATA_W-1:0] rdata2;
        logic [DATA_W-1:0] imm;
        logic [3:0]        shamt;
    } bundle_t;

    // Opcode-word state parked while waiting for the immediate; dst doubles as rs1.
    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic              reg_write;
        logic              mem_read;
        logic [AW-1:0]     dst;
        logic [AW-1:0]     rs2;
        logic [DATA_W-1:0] rdata1;
        logic [DATA_W-1:0] rdata2;
        logic [3:0]        shamt;
    } hold_t;

    state_t            state_q, state_d;
    logic              valid_q, valid_d;
    bundle_t           bundle_q, bundle_d;
    hold_t             hold_q, hold_d;
    logic [DATA_W-1:0] rf_q [N_REGS];
    logic [DATA_W-1:0] rf_d [N_REGS];

    logic [AW-1:0]     rs1_c, rs2_c;
    logic [DATA_W-1:0] rdata1_c, rdata2_c;
    logic              hazard_c;

    assign rs1_c    = instruction[8 +: AW];
    assign rs2_c    = instruction[5 +: AW];
    assign rdata1_c = (wb_we && wb_addr == rs1_c) ? wb_data : rf_q[rs1_c];
    assign rdata2_c = (wb_we && wb_addr == rs2_c) ? wb_data : rf_q[rs2_c];

    // Load-use: the load in ID/EX cannot forward in time to this word's sources.
    assign hazard_c = (state_q == S_DECODE) && instr_valid && valid_q
                   && bundle_q.mem_read && bundle_q.reg_write
                   && (bundle_q.dst == rs1_c || bundle_q.dst == rs2_c);

    assign stall_out = hazard_c && !flush && reset;

    always_comb begin
        rf_d = rf_q;
        if (wb_we) begin
            rf_d[wb_addr] = wb_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        valid_d  = 1'b0;
        bundle_d = '0;
        hold_d   = hold_q;
        if (flush) begin
            hold_d  = '0;
            state_d = S_DECODE;
        end else begin
            unique case (state_q)
                S_DECODE: begin
                    if (instr_valid && !hazard_c) begin
                        if (ctrl_needs_imm) begin
                            hold_d.ctrl      = ctrl_in;
                            hold_d.reg_write = ctrl_reg_write;
                            hold_d.mem_read  = ctrl_mem_read;
                            hold_d.dst       = rs1_c;
                            hold_d.rs2       = rs2_c;
                            hold_d.rdata1    = rdata1_c;
                            hold_d.rdata2    = rdata2_c;
                            hold_d.shamt     = instruction[3:0];
                            state_d          = S_IMM;
                        end else begin
                            bundle_d.ctrl      = ctrl_in;
                            bundle_d.reg_write = ctrl_reg_write;
                            bundle_d.mem_read  = ctrl_mem_read;
                            bundle_d.dst       = rs1_c;
                            bundle_d.rdata1    = rdata1_c;
                            bundle_d.rdata2    = rdata2_c;
                            bundle_d.shamt     = instruction[3:0];
                            valid_d            = 1'b1;
                        end
                    end
                end
                S_IMM: begin
                    // Keep parked operands coherent with writebacks, including this cycle's.
                    if (wb_we && wb_addr == hold_q.dst) begin
                        hold_d.rdata1 = wb_data;
                    end
                    if (wb_we && wb_addr == hold_q.rs2) begin
                        hold_d.rdata2 = wb_data;
                    end
                    if (instr_valid) begin
                        bundle_d.ctrl      = hold_d.ctrl;
                        bundle_d.reg_write = hold_d.reg_write;
                        bundle_d.mem_read  = hold_d.mem_read;
                        bundle_d.dst       = hold_d.dst;
                        bundle_d.rdata1    = hold_d.rdata1;
                        bundle_d.rdata2    = hold_d.rdata2;
                        bundle_d.shamt     = hold_d.shamt;
                        bundle_d.imm       = DATA_W'(instruction);
                        valid_d            = 1'b1;
                        hold_d             = '0;
                        state_d            = S_DECODE;
                    end
                end
                default: state_d = S_DECODE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_DECODE;
            valid_q  <= 1'b0;
            bundle_q <= '0;
            hold_q   <= '0;
            rf_q     <= '{default: '0};
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
            hold_q   <= hold_d;
            rf_q     <= rf_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_ctrl      = bundle_q.ctrl;
    assign out_reg_write = bundle_q.reg_write;
    assign out_mem_read  = bundle_q.mem_read;
    assign out_dst       = bundle_q.dst;
    assign out_rdata1    = bundle_q.rdata1;
    assign out_rdata2    = bundle_q.rdata2;
    assign out_imm       = bundle_q.imm;
    assign out_shamt     = bundle_q.shamt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed literal checks plus randomized traffic against
// an instruction-level model that reads architectural registers at issue time.
module tb_id_ex_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Default configuration (DATA_W=16, N_REGS=8)
    logic        t_rst_n, t_iv, t_rw, t_mr, t_ni, t_fl, t_we;
    logic [15:0] t_instr, t_wd;
    logic [23:0] t_ctrl;
    logic [2:0]  t_wa;
    logic        stall_out, out_valid, out_reg_write, out_mem_read;
    logic [23:0] out_ctrl;
    logic [2:0]  out_dst;
    logic [15:0] out_rdata1, out_rdata2, out_imm;
    logic [3:0]  out_shamt;

    id_ex_stage u_dut (
        .clk(clk), .reset(t_rst_n), .instr_valid(t_iv), .instruction(t_instr),
        .ctrl_in(t_ctrl), .ctrl_reg_write(t_rw), .ctrl_mem_read(t_mr),
        .ctrl_needs_imm(t_ni), .flush(t_fl), .wb_we(t_we), .wb_addr(t_wa),
        .wb_data(t_wd), .stall_out(stall_out), .out_valid(out_valid),
        .out_ctrl(out_ctrl), .out_reg_write(out_reg_write),
        .out_mem_read(out_mem_read), .out_dst(out_dst), .out_rdata1(out_rdata1),
        .out_rdata2(out_rdata2), .out_imm(out_imm), .out_shamt(out_shamt)
    );

    // Wide configuration (DATA_W=32, N_REGS=4)
    logic        w_rst_n, w_iv, w_rw, w_we, w_stall, w_valid, w_rwo, w_mro;
    logic [15:0] w_instr;
    logic [23:0] w_ctrl, w_ctrlo;
    logic [1:0]  w_wa, w_dst;
    logic [31:0] w_wd, w_rd1, w_rd2, w_imm;
    logic [3:0]  w_shamt;

    id_ex_stage #(.DATA_W(32), .N_REGS(4), .CTRL_W(24)) u_dut_w (
        .clk(clk), .reset(w_rst_n), .instr_valid(w_iv), .instruction(w_instr),
        .ctrl_in(w_ctrl), .ctrl_reg_write(w_rw), .ctrl_mem_read(1'b0),
        .ctrl_needs_imm(1'b0), .flush(1'b0), .wb_we(w_we), .wb_addr(w_wa),
        .wb_data(w_wd), .stall_out(w_stall), .out_valid(w_valid),
        .out_ctrl(w_ctrlo), .out_reg_write(w_rwo), .out_mem_read(w_mro),
        .out_dst(w_dst), .out_rdata1(w_rd1), .out_rdata2(w_rd2),
        .out_imm(w_imm), .out_shamt(w_shamt)
    );

    // Model: architectural registers, expected ID/EX contents, pending opcode word.
    logic [15:0] m_regs [8];
    logic        m_valid, m_rw, m_mr, m_partial, exp_stall;
    logic [23:0] m_ctrl, p_ctrl;
    logic [2:0]  m_dst, p_rs1, p_rs2;
    logic [15:0] m_rd1, m_rd2, m_imm;
    logic [3:0]  m_shamt, p_shamt;
    logic        p_rw, p_mr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic logic [15:0] m_read(input logic [2:0] a);
        return (t_we && t_wa == a) ? t_wd : m_regs[a];
    endfunction

    task automatic model_step();
        logic [2:0]  rs1, rs2;
        logic        hz, x_v, x_rw, x_mr;
        logic [23:0] x_c;
        logic [2:0]  x_d;
        logic [15:0] x_1, x_2, x_i;
        logic [3:0]  x_s;
        rs1 = t_instr[10:8];
        rs2 = t_instr[7:5];
        hz  = !m_partial && t_iv && m_valid && m_mr && m_rw && (m_dst == rs1 || m_dst == rs2);
        exp_stall = t_rst_n && hz && !t_fl;
        x_v = 1'b0; x_c = '0; x_rw = 1'b0; x_mr = 1'b0; x_d = '0;
        x_1 = '0; x_2 = '0; x_i = '0; x_s = '0;
        if (!t_rst_n) begin
            m_partial = 1'b0;
            for (int i = 0; i < 8; i++) m_regs[i] = '0;
        end else begin
            if (t_fl) begin
                m_partial = 1'b0;
            end else if (!m_partial) begin
                if (t_iv && !hz) begin
                    if (t_ni) begin
                        m_partial = 1'b1;
                        p_ctrl = t_ctrl; p_rw = t_rw; p_mr = t_mr;
                        p_rs1 = rs1; p_rs2 = rs2; p_shamt = t_instr[3:0];
                    end else begin
                        x_v = 1'b1; x_c = t_ctrl; x_rw = t_rw; x_mr = t_mr; x_d = rs1;
                        x_1 = m_read(rs1); x_2 = m_read(rs2); x_s = t_instr[3:0];
                    end
                end
            end else if (t_iv) begin
                x_v = 1'b1; x_c = p_ctrl; x_rw = p_rw; x_mr = p_mr; x_d = p_rs1;
                x_1 = m_read(p_rs1); x_2 = m_read(p_rs2); x_s = p_shamt; x_i = t_instr;
                m_partial = 1'b0;
            end
            if (t_we) m_regs[t_wa] = t_wd;
        end
        m_valid = x_v; m_ctrl = x_c; m_rw = x_rw; m_mr = x_mr; m_dst = x_d;
        m_rd1 = x_1; m_rd2 = x_2; m_imm = x_i; m_shamt = x_s;
    endtask

    // Called right after a falling edge with inputs already driven.
    task automatic cycle();
        #1;
        model_step();
        chk("stall_out", 64'(stall_out), 64'(exp_stall));
        @(negedge clk);
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("out_ctrl", 64'(out_ctrl), 64'(m_ctrl));
        chk("out_reg_write", 64'(out_reg_write), 64'(m_rw));
        chk("out_mem_read", 64'(out_mem_read), 64'(m_mr));
        if (m_valid) begin
            chk("out_dst", 64'(out_dst), 64'(m_dst));
            chk("out_rdata1", 64'(out_rdata1), 64'(m_rd1));
            chk("out_rdata2", 64'(out_rdata2), 64'(m_rd2));
            chk("out_imm", 64'(out_imm), 64'(m_imm));
            chk("out_shamt", 64'(out_shamt), 64'(m_shamt));
        end
    endtask

    task automatic drv(input logic iv, input logic [15:0] ins, input logic [23:0] c,
                       input logic rw, input logic mr, input logic ni, input logic fl,
                       input logic we, input logic [2:0] wa, input logic [15:0] wd);
        t_iv = iv; t_instr = ins; t_ctrl = c; t_rw = rw; t_mr = mr; t_ni = ni;
        t_fl = fl; t_we = we; t_wa = wa; t_wd = wd;
    endtask

    initial begin
        logic prev_stall;
        m_valid = 1'b0; m_partial = 1'b0; m_rw = 1'b0; m_mr = 1'b0; m_dst = '0;
        m_ctrl = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0; m_shamt = '0;
        p_ctrl = '0; p_rw = 1'b0; p_mr = 1'b0; p_rs1 = '0; p_rs2 = '0; p_shamt = '0;
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        w_rst_n = 1'b0; w_iv = 1'b0; w_rw = 1'b0; w_we = 1'b0;
        w_instr = '0; w_ctrl = '0; w_wa = '0; w_wd = '0;
        t_rst_n = 1'b0;
        drv(0, 16'h0, 24'h0, 0, 0, 0, 0, 0, 3'd0, 16'h0);
        @(negedge clk);

        // Reset held for two cycles
        cycle(); cycle();
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_ctrl", 64'(out_ctrl), 64'h0);
        chk("rst_rdata1", 64'(out_rdata1), 64'h0);
        t_rst_n = 1'b1;

        // All eight registers read zero after reset
        for (int i = 0; i < 4; i++) begin
            drv(1, 16'(i << 8) | 16'((i + 4) << 5), 24'h1, 0, 0, 0, 0, 0, 3'd0, 16'h0);
            cycle();
            chk("rf_zero_rs1", 64'(out_rdata1), 64'h0);
            chk("rf_zero_rs2", 64'(out_rdata2), 64'h0);
        end

        // Same-cycle writeback bypass
        drv(1, 16'h0300, 24'hABCDEF, 1, 0, 0, 0, 1, 3'd3, 16'hBEEF);
        cycle();
        chk("bypass_rdata1", 64'(out_rdata1), 64'hBEEF);
        chk("bypass_valid", 64'(out_valid), 64'h1);

        // Load into R2, then a consumer of R2 as rs2
        drv(1, 16'h0200, 24'h000111, 1, 1, 0, 0, 0, 3'd0, 16'h0);
        cycle();
        chk("load_dst", 64'(out_dst), 64'h2);
        drv(1, 16'h0040, 24'h000222, 0, 0, 0, 0, 0, 3'd0, 16'h0);
        #1 chk("loaduse_stall", 64'(stall_out), 64'h1);
        cycle();
        chk("loaduse_bubble", 64'(out_valid), 64'h0);
        #1 chk("loaduse_released", 64'(stall_out), 64'h0);
        cycle();
        chk("loaduse_issue", 64'(out_valid), 64'h1);
        chk("loaduse_ctrl", 64'(out_ctrl), 64'h000222);

        // Two-word instruction with a writeback to its rs1 while waiting
        drv(1, 16'h0507, 24'h000333, 1, 0, 1, 0, 0, 3'd0, 16'h0);
        cycle();
        chk("imm_opcode_bubble", 64'(out_valid), 64'h0);
        drv(0, 16'h0, 24'h0, 0, 0, 0, 0, 1, 3'd5, 16'h00AA);
        cycle();
        chk("imm_wait_bubble", 64'(out_valid), 64'h0);
        drv(1, 16'h1234, 24'h0, 0, 0, 0, 0, 0, 3'd0, 16'h0);
        cycle();
        chk("imm_valid", 64'(out_valid), 64'h1);
        chk("imm_value", 64'(out_imm), 64'h1234);
        chk("imm_rdata1", 64'(out_rdata1), 64'h00AA);
        chk("imm_shamt", 64'(out_shamt), 64'h7);
        drv(0, 16'h0, 24'h0, 0, 0, 0, 0, 0, 3'd0, 16'h0);
        cycle();
        chk("imm_once", 64'(out_valid), 64'h0);

        // Flush while waiting for an immediate, then a single-word instruction
        drv(1, 16'h0608, 24'h000444, 1, 0, 1, 0, 0, 3'd0, 16'h0);
        cycle();
        drv(1, 16'hFFFF, 24'h0, 0, 0, 0, 1, 0, 3'd0, 16'h0);
        cycle();
        chk("flush_bubble", 64'(out_valid), 64'h0);
        drv(1, 16'h0165, 24'h000555, 0, 0, 0, 0, 0, 3'd0, 16'h0);
        cycle();
        chk("post_flush_valid", 64'(out_valid), 64'h1);
        chk("post_flush_ctrl", 64'(out_ctrl), 64'h000555);
        chk("post_flush_dst", 64'(out_dst), 64'h1);
        chk("post_flush_rdata2", 64'(out_rdata2), 64'hBEEF);
        chk("post_flush_imm", 64'(out_imm), 64'h0);

        // Randomized traffic; fetch re-presents the word after a stall
        prev_stall = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!prev_stall) begin
                t_iv    = ($urandom_range(9) < 8);
                t_instr = 16'($urandom);
                t_ctrl  = 24'($urandom);
                t_rw    = 1'($urandom);
                t_mr    = ($urandom_range(4) < 2);
                t_ni    = ($urandom_range(3) == 0);
            end
            t_fl    = ($urandom_range(19) == 0);
            t_we    = 1'($urandom);
            t_wa    = 3'($urandom);
            t_wd    = 16'($urandom);
            t_rst_n = ($urandom_range(99) != 0);
            if (m_partial && t_iv) t_we = 1'b0;
            cycle();
            prev_stall = exp_stall;
        end

        // Wide configuration: 2-bit register fields at [9:8]/[6:5], 32-bit data
        drv(0, 16'h0, 24'h0, 0, 0, 0, 0, 0, 3'd0, 16'h0);
        w_rst_n = 1'b1; w_we = 1'b1; w_wa = 2'd2; w_wd = 32'h12345678;
        @(negedge clk);
        w_wa = 2'd1; w_wd = 32'hDEADBEEF;
        w_iv = 1'b1; w_instr = 16'h05C0; w_ctrl = 24'h000777; w_rw = 1'b1;
        @(negedge clk);
        chk("wide_valid", 64'(w_valid), 64'h1);
        chk("wide_bypass_rdata1", 64'(w_rd1), 64'hDEADBEEF);
        chk("wide_rdata2", 64'(w_rd2), 64'h12345678);
        chk("wide_dst", 64'(w_dst), 64'h1);
        w_we = 1'b0; w_instr = 16'h0100; w_rw = 1'b0;
        @(negedge clk);
        chk("wide_stored_rdata1", 64'(w_rd1), 64'hDEADBEEF);
        chk("wide_r0_rdata2", 64'(w_rd2), 64'h0);
        chk("wide_stall", 64'(w_stall), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
